// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - two-port round-robin arbiter in front of a single I2C master
module i2c_master_arbiter #(
    parameter int unsigned EN_HOLD        = 250,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       m_en,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_data_in,
    input  logic       m_busy,
    input  logic [7:0] m_data_out,
    input  logic       conflict
);

    // Counter widths: the timeout counter never drops below 16 bits.
    localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_W    = (TO_BITS > 16) ? TO_BITS : 16;
    localparam int unsigned EN_BITS = $clog2(EN_HOLD + 1);
    localparam int unsigned EN_W    = (EN_BITS > 1) ? EN_BITS : 1;

    // Terminal counts: the counters start at 0 on the grant edge, so the
    // edge that sees count == N-1 is the N-th edge after grant.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [EN_W-1:0] EN_LAST = EN_W'(EN_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RISE,
        ST_WAIT_FALL,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;            // port preferred on the next contended grant
    logic            sel_q, sel_d;          // port owning the transaction in flight
    logic [6:0]      addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [EN_W-1:0] en_cnt_q, en_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            busy_seen_q, busy_seen_d;
    logic            conf_q, conf_d;        // sticky address-conflict flag
    logic            m_en_q, m_en_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            err0_q, err0_d;
    logic            err1_q, err1_d;
    logic [7:0]      rdata0_q, rdata0_d;
    logic [7:0]      rdata1_q, rdata1_d;

    logic            pick;
    logic            to_hit;
    logic            conf_now;

    // Next-state and output logic; every registered output is decided here.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        en_cnt_d    = en_cnt_q;
        to_cnt_d    = to_cnt_q;
        busy_seen_d = busy_seen_q;
        conf_d      = conf_q;
        m_en_d      = m_en_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        pick        = 1'b0;
        to_hit      = (to_cnt_q == TO_LAST);
        conf_now    = conf_q | conflict;

        case (state_q)
            ST_IDLE: begin
                conf_d      = 1'b0;
                busy_seen_d = 1'b0;
                if (!m_busy && (req0 || req1)) begin
                    // Contention goes to the pointer; a lone request wins outright.
                    pick     = (req0 && req1) ? rr_q : req1;
                    sel_d    = pick;
                    rr_d     = ~pick;
                    addr_d   = pick ? addr1 : addr0;
                    rw_d     = pick ? rw1 : rw0;
                    wdata_d  = pick ? wdata1 : wdata0;
                    gnt0_d   = ~pick;
                    gnt1_d   = pick;
                    m_en_d   = 1'b1;
                    en_cnt_d = '0;
                    to_cnt_d = '0;
                    state_d  = ST_ISSUE;
                end
            end

            ST_ISSUE, ST_WAIT_RISE, ST_WAIT_FALL: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                conf_d   = conf_now;
                if (to_hit) begin
                    // Abort: report an error and leave rdata alone.
                    m_en_d  = 1'b0;
                    state_d = ST_DONE;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    err0_d  = ~sel_q;
                    err1_d  = sel_q;
                end else if (state_q == ST_ISSUE) begin
                    busy_seen_d = busy_seen_q | m_busy;
                    if (en_cnt_q == EN_LAST) begin
                        // A master that already went busy skips the rise wait.
                        m_en_d  = 1'b0;
                        state_d = (busy_seen_q || m_busy) ? ST_WAIT_FALL : ST_WAIT_RISE;
                    end else begin
                        en_cnt_d = en_cnt_q + EN_W'(1);
                    end
                end else if (state_q == ST_WAIT_RISE) begin
                    if (m_busy) begin
                        state_d = ST_WAIT_FALL;
                    end
                end else if (!m_busy) begin
                    state_d = ST_DONE;
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    err0_d  = ~sel_q & conf_now;
                    err1_d  = sel_q & conf_now;
                    if (rw_q) begin
                        if (sel_q) begin
                            rdata1_d = m_data_out;
                        end else begin
                            rdata0_d = m_data_out;
                        end
                    end
                end
            end

            ST_DONE: begin
                conf_d      = 1'b0;
                busy_seen_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            en_cnt_q    <= '0;
            to_cnt_q    <= '0;
            busy_seen_q <= 1'b0;
            conf_q      <= 1'b0;
            m_en_q      <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            en_cnt_q    <= en_cnt_d;
            to_cnt_q    <= to_cnt_d;
            busy_seen_q <= busy_seen_d;
            conf_q      <= conf_d;
            m_en_q      <= m_en_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign m_en      = m_en_q;
    assign m_addr    = addr_q;
    assign m_rw      = rw_q;
    assign m_data_in = wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - randomized self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    localparam int EN_HOLD = 250;
    localparam int TO      = 20000;

    logic       clk = 1'b0;
    logic       arst;
    logic       req0, req1;
    logic [6:0] addr0, addr1;
    logic       rw0, rw1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       m_en;
    logic [6:0] m_addr;
    logic       m_rw;
    logic [7:0] m_data_in;
    logic       m_busy;
    logic [7:0] m_data_out;
    logic       conflict;

    always #5 clk = ~clk;

    i2c_master_arbiter #(.EN_HOLD(EN_HOLD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .arst(arst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .rw0(rw0), .rw1(rw1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .m_en(m_en), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
        .m_busy(m_busy), .m_data_out(m_data_out), .conflict(conflict)
    );

    int vec  = 0;
    int errs = 0;

    // Reference model state: round-robin preference and last read data per port.
    int         rr_m;
    logic [7:0] rd_m [2];

    // Observations of one transaction, filled by run_txn.
    int         obs_done_k, obs_en_cnt, obs_en_fall_k;
    logic       obs_done0, obs_done1, obs_err0, obs_err1, obs_men, obs_after;
    logic [7:0] obs_rdata0, obs_rdata1;
    bit         obs_unstable, obs_stray;

    // Expected done edge (counted from grant) for a master busy on edges a..b.
    function automatic int exp_done_k(input int a, input int b);
        int k;
        if (b < a) return TO;
        k = (b + 1 > EN_HOLD + 1) ? b + 1 : EN_HOLD + 1;
        return (k < TO) ? k : TO;
    endfunction

    task automatic do_reset();
        arst = 1'b1; req0 = 1'b0; req1 = 1'b0; m_busy = 1'b0; conflict = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst = 1'b0;
        rr_m = 0; rd_m[0] = 8'h00; rd_m[1] = 8'h00;
    endtask

    // Plays the I2C master for one transaction, starting just after the grant edge.
    task automatic run_txn(input int a, input int b, input int conf_k, input logic [7:0] rd,
                           input logic [6:0] ex_addr, input logic ex_rw, input logic [7:0] ex_data,
                           input int limit, input bit jitter);
        obs_done_k = -1; obs_en_fall_k = -1; obs_en_cnt = (m_en === 1'b1) ? 1 : 0;
        obs_unstable = 0; obs_stray = 0; obs_after = 1'b0; obs_men = 1'b0;
        obs_done0 = 1'b0; obs_done1 = 1'b0; obs_err0 = 1'b0; obs_err1 = 1'b0;
        obs_rdata0 = 8'h00; obs_rdata1 = 8'h00;
        for (int k = 1; k <= limit; k++) begin
            m_busy = (k >= a && k <= b); conflict = (k == conf_k); m_data_out = rd;
            if (jitter) begin
                req0 = 1'($urandom); req1 = 1'($urandom);
                addr0 = 7'($urandom); addr1 = 7'($urandom); rw0 = 1'($urandom); rw1 = 1'($urandom);
                wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            end
            @(posedge clk); #1;
            if (m_en === 1'b1) obs_en_cnt++;
            else if (obs_en_fall_k < 0) obs_en_fall_k = k;
            if (m_addr !== ex_addr || m_rw !== ex_rw || m_data_in !== ex_data) obs_unstable = 1;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ((err0 || err1) && !(done0 || done1))) obs_stray = 1;
            if (done0 === 1'b1 || done1 === 1'b1) begin
                obs_done_k = k; obs_done0 = done0; obs_done1 = done1; obs_err0 = err0; obs_err1 = err1;
                obs_rdata0 = rdata0; obs_rdata1 = rdata1; obs_men = m_en;
                break;
            end
        end
        m_busy = 1'b0; conflict = 1'b0;
        if (jitter) begin req0 = 1'b0; req1 = 1'b0; end
        if (obs_done_k > 0) begin
            @(posedge clk); #1;
            obs_after = done0 | done1 | err0 | err1 | gnt0 | gnt1;
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; req0 = 1'b1; req1 = 1'b1; m_busy = 1'b0; conflict = 1'b0;
        addr0 = 7'($urandom); addr1 = 7'($urandom); rw0 = 1'b1; rw1 = 1'b1;
        wdata0 = 8'($urandom); wdata1 = 8'($urandom); m_data_out = 8'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec++;
        if ({gnt0, gnt1, done0, done1, err0, err1, m_en, m_rw, rdata0, rdata1, m_addr, m_data_in} !== 39'd0) begin
            errs++;
            $display("FAIL reset_outputs: got gnt=%b%b done=%b%b err=%b%b m_en=%b rdata=%h/%h m_addr=%h m_data_in=%h expected all 0",
                     gnt1, gnt0, done1, done0, err1, err0, m_en, rdata1, rdata0, m_addr, m_data_in);
        end
        req0 = 1'b0; req1 = 1'b0; arst = 1'b0;
        rr_m = 0; rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        @(posedge clk); #1;
        vec++;
        if ({gnt1, gnt0, m_en} !== 3'b000) begin
            errs++; $display("FAIL reset_idle: got gnt=%b%b m_en=%b expected 000", gnt1, gnt0, m_en);
        end
    endtask

    task automatic test_write();
        int a, b, dk;
        a = $urandom_range(1, EN_HOLD + 30); b = a + $urandom_range(0, 30);
        req0 = 1'b1; addr0 = 7'h48; rw0 = 1'b0; wdata0 = 8'hB3; m_busy = 1'b0;
        @(posedge clk); #1;
        vec++;
        if ({gnt1, gnt0, m_en} !== 3'b011) begin
            errs++; $display("FAIL wr_grant: got gnt=%b%b m_en=%b expected gnt=01 m_en=1", gnt1, gnt0, m_en);
        end
        vec++;
        if ({m_addr, m_rw, m_data_in} !== {7'h48, 1'b0, 8'hB3}) begin
            errs++; $display("FAIL wr_latch: got addr=%h rw=%b data=%h expected 48/0/b3", m_addr, m_rw, m_data_in);
        end
        req0 = 1'b0; rr_m = 1;
        run_txn(a, b, -1, 8'h5A, 7'h48, 1'b0, 8'hB3, TO + 5, 1'b0);
        dk = exp_done_k(a, b);
        vec++;
        if (obs_en_cnt != EN_HOLD || obs_en_fall_k != EN_HOLD) begin
            errs++; $display("FAIL wr_en_hold: got high=%0d fall=%0d expected %0d", obs_en_cnt, obs_en_fall_k, EN_HOLD);
        end
        vec++;
        if (obs_done_k != dk) begin
            errs++; $display("FAIL wr_done_edge: got %0d expected %0d (busy %0d..%0d)", obs_done_k, dk, a, b);
        end
        vec++;
        if ({obs_done1, obs_done0, obs_err1, obs_err0} !== 4'b0100) begin
            errs++; $display("FAIL wr_done_err: got done=%b%b err=%b%b expected done=01 err=00", obs_done1, obs_done0, obs_err1, obs_err0);
        end
        vec++;
        if ({obs_rdata1, obs_rdata0} !== {rd_m[1], rd_m[0]}) begin
            errs++; $display("FAIL wr_rdata: got %h/%h expected %h/%h", obs_rdata1, obs_rdata0, rd_m[1], rd_m[0]);
        end
        vec++;
        if (obs_unstable || obs_stray || obs_after !== 1'b0) begin
            errs++; $display("FAIL wr_clean: got unstable=%0d stray=%0d after=%b expected 0/0/0", obs_unstable, obs_stray, obs_after);
        end
    endtask

    task automatic test_read();
        int a, b, dk;
        a = $urandom_range(1, 40); b = EN_HOLD + $urandom_range(0, 20);
        req1 = 1'b1; addr1 = 7'h4F; rw1 = 1'b1; wdata1 = 8'($urandom); m_busy = 1'b0;
        @(posedge clk); #1;
        vec++;
        if ({gnt1, gnt0, m_addr, m_rw} !== {2'b10, 7'h4F, 1'b1}) begin
            errs++; $display("FAIL rd_grant: got gnt=%b%b addr=%h rw=%b expected 10/4f/1", gnt1, gnt0, m_addr, m_rw);
        end
        req1 = 1'b0; rr_m = 0;
        run_txn(a, b, -1, 8'h75, 7'h4F, 1'b1, wdata1, TO + 5, 1'b0);
        dk = exp_done_k(a, b);
        rd_m[1] = 8'h75;
        vec++;
        if (obs_done_k != dk || {obs_done1, obs_done0, obs_err1, obs_err0} !== 4'b1000) begin
            errs++; $display("FAIL rd_done: got edge=%0d done=%b%b err=%b%b expected edge=%0d done=10 err=00",
                             obs_done_k, obs_done1, obs_done0, obs_err1, obs_err0, dk);
        end
        vec++;
        if ({obs_rdata1, obs_rdata0} !== {rd_m[1], rd_m[0]}) begin
            errs++; $display("FAIL rd_rdata: got %h/%h expected %h/%h", obs_rdata1, obs_rdata0, rd_m[1], rd_m[0]);
        end
    endtask

    task automatic test_req_drop();
        m_busy = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin req1 = 1'b0; m_busy = 1'b0; end
            @(posedge clk); #1;
            vec++;
            if ({gnt1, gnt0, m_en} !== 3'b000) begin
                errs++; $display("FAIL drop_no_grant: cycle %0d got gnt=%b%b m_en=%b expected 000", c, gnt1, gnt0, m_en);
            end
        end
    endtask

    task automatic test_random();
        int p, mode, a, b, dk;
        logic [7:0] rd, ed;
        logic [6:0] ea;
        logic       er;
        for (int i = 0; i < 8; i++) begin
            mode = $urandom_range(0, 2);
            addr0 = 7'($urandom); addr1 = 7'($urandom); rw0 = 1'($urandom); rw1 = 1'($urandom);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom);
            req0 = (mode != 1); req1 = (mode != 0); m_busy = 1'b0;
            p  = (mode == 2) ? rr_m : mode;
            ea = (p != 0) ? addr1 : addr0;
            er = (p != 0) ? rw1 : rw0;
            ed = (p != 0) ? wdata1 : wdata0;
            rd = 8'($urandom);
            a = $urandom_range(1, EN_HOLD + 40); b = a + $urandom_range(0, 40);
            @(posedge clk); #1;
            vec++;
            if ({gnt1, gnt0} !== ((p != 0) ? 2'b10 : 2'b01)) begin
                errs++; $display("FAIL rnd%0d_grant: got gnt=%b%b expected port %0d (mode %0d)", i, gnt1, gnt0, p, mode);
            end
            vec++;
            if ({m_addr, m_rw, m_data_in} !== {ea, er, ed}) begin
                errs++; $display("FAIL rnd%0d_latch: got %h/%b/%h expected %h/%b/%h", i, m_addr, m_rw, m_data_in, ea, er, ed);
            end
            rr_m = 1 - p;
            run_txn(a, b, -1, rd, ea, er, ed, TO + 5, 1'b1);
            dk = exp_done_k(a, b);
            if (er) rd_m[p] = rd;
            vec++;
            if (obs_done_k != dk || {obs_done1, obs_done0, obs_err1, obs_err0} !== ((p != 0) ? 4'b1000 : 4'b0100)) begin
                errs++; $display("FAIL rnd%0d_done: got edge=%0d done=%b%b err=%b%b expected edge=%0d port %0d err=0",
                                 i, obs_done_k, obs_done1, obs_done0, obs_err1, obs_err0, dk, p);
            end
            vec++;
            if ({obs_rdata1, obs_rdata0} !== {rd_m[1], rd_m[0]}) begin
                errs++; $display("FAIL rnd%0d_rdata: got %h/%h expected %h/%h", i, obs_rdata1, obs_rdata0, rd_m[1], rd_m[0]);
            end
            vec++;
            if (obs_en_cnt != EN_HOLD || obs_unstable || obs_stray || obs_after !== 1'b0) begin
                errs++; $display("FAIL rnd%0d_clean: got en_high=%0d unstable=%0d stray=%0d after=%b expected %0d/0/0/0",
                                 i, obs_en_cnt, obs_unstable, obs_stray, obs_after, EN_HOLD);
            end
        end
    endtask

    task automatic test_contention();
        int p, a, b;
        do_reset();
        addr0 = 7'h21; addr1 = 7'h62; rw0 = 1'b0; rw1 = 1'b0; wdata0 = 8'h11; wdata1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1; m_busy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            p = n % 2;
            if (n == 1) begin
                m_busy = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    vec++;
                    if ({gnt1, gnt0} !== 2'b00) begin
                        errs++; $display("FAIL cont_busy_hold%0d: got gnt=%b%b expected 00", c, gnt1, gnt0);
                    end
                end
                m_busy = 1'b0;
            end
            @(posedge clk); #1;
            vec++;
            if ({gnt1, gnt0} !== ((p != 0) ? 2'b10 : 2'b01) || m_addr !== ((p != 0) ? 7'h62 : 7'h21)) begin
                errs++; $display("FAIL cont_grant%0d: got gnt=%b%b addr=%h expected port %0d", n, gnt1, gnt0, m_addr, p);
            end
            rr_m = 1 - p;
            a = $urandom_range(1, 30); b = a + $urandom_range(0, 30);
            run_txn(a, b, -1, 8'h00, (p != 0) ? 7'h62 : 7'h21, 1'b0, (p != 0) ? 8'h22 : 8'h11, TO + 5, 1'b0);
            vec++;
            if (obs_done_k != exp_done_k(a, b) || {obs_done1, obs_done0} !== ((p != 0) ? 2'b10 : 2'b01)) begin
                errs++; $display("FAIL cont_done%0d: got edge=%0d done=%b%b expected edge=%0d port %0d",
                                 n, obs_done_k, obs_done1, obs_done0, exp_done_k(a, b), p);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_conflict();
        logic [7:0] rd;
        for (int n = 0; n < 2; n++) begin
            rd = 8'($urandom);
            req1 = 1'b1; addr1 = 7'($urandom); rw1 = 1'b1; wdata1 = 8'($urandom); m_busy = 1'b0;
            @(posedge clk); #1;
            vec++;
            if ({gnt1, gnt0} !== 2'b10) begin
                errs++; $display("FAIL conf%0d_grant: got gnt=%b%b expected 10", n, gnt1, gnt0);
            end
            req1 = 1'b0; rr_m = 0;
            run_txn(3, EN_HOLD + 20, (n == 0) ? EN_HOLD + 8 : -1, rd, addr1, 1'b1, wdata1, TO + 5, 1'b0);
            rd_m[1] = rd;
            vec++;
            if (obs_done_k != EN_HOLD + 21 || {obs_done1, obs_err1, obs_err0} !== {1'b1, (n == 0), 1'b0}) begin
                errs++; $display("FAIL conf%0d_done: got edge=%0d done1=%b err=%b%b expected edge=%0d err1=%0d",
                                 n, obs_done_k, obs_done1, obs_err1, obs_err0, EN_HOLD + 21, (n == 0));
            end
            vec++;
            if (obs_rdata1 !== rd_m[1]) begin
                errs++; $display("FAIL conf%0d_rdata: got %h expected %h", n, obs_rdata1, rd_m[1]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] rd;
        rd = ~rd_m[0];
        req0 = 1'b1; addr0 = 7'($urandom); rw0 = 1'b1; wdata0 = 8'($urandom); m_busy = 1'b0;
        @(posedge clk); #1;
        vec++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errs++; $display("FAIL to_grant: got gnt=%b%b expected 01", gnt1, gnt0);
        end
        req0 = 1'b0; rr_m = 1;
        run_txn(1, 0, -1, rd, addr0, 1'b1, wdata0, TO + 5, 1'b0);
        vec++;
        if (obs_done_k != TO || {obs_done1, obs_done0, obs_err1, obs_err0, obs_men} !== 5'b01010) begin
            errs++; $display("FAIL to_done: got edge=%0d done=%b%b err=%b%b m_en=%b expected edge=%0d done=01 err=01 m_en=0",
                             obs_done_k, obs_done1, obs_done0, obs_err1, obs_err0, obs_men, TO);
        end
        vec++;
        if (obs_rdata0 !== rd_m[0] || obs_en_cnt != EN_HOLD) begin
            errs++; $display("FAIL to_rdata: got rdata0=%h en_high=%0d expected %h/%0d", obs_rdata0, obs_en_cnt, rd_m[0], EN_HOLD);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1'b1; addr0 = 7'($urandom); rw0 = 1'b1; wdata0 = 8'($urandom); m_busy = 1'b0;
        @(posedge clk); #1;
        vec++;
        if ({gnt1, gnt0} !== 2'b01) begin
            errs++; $display("FAIL rm_grant: got gnt=%b%b expected 01", gnt1, gnt0);
        end
        req0 = 1'b0;
        run_txn(1, EN_HOLD + 50, -1, 8'hC3, addr0, 1'b1, wdata0, EN_HOLD + 10, 1'b0);
        vec++;
        if (obs_done_k != -1) begin
            errs++; $display("FAIL rm_early_done: got done at edge %0d expected none", obs_done_k);
        end
        arst = 1'b1; m_busy = 1'b1;
        @(posedge clk); #1;
        vec++;
        if ({gnt0, gnt1, done0, done1, err0, err1, m_en, m_rw, rdata0, rdata1, m_addr, m_data_in} !== 39'd0) begin
            errs++; $display("FAIL rm_outputs: got done=%b%b m_en=%b m_addr=%h m_data_in=%h m_rw=%b expected all 0",
                             done1, done0, m_en, m_addr, m_data_in, m_rw);
        end
        arst = 1'b0; m_busy = 1'b0; rr_m = 0; rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        @(posedge clk); #1;
        vec++;
        if ({done0, done1, err0, err1, gnt0, gnt1} !== 6'd0) begin
            errs++; $display("FAIL rm_no_done: got done=%b%b err=%b%b expected 0", done1, done0, err1, err0);
        end
        req0 = 1'b1;
        @(posedge clk); #1;
        vec++;
        if ({gnt1, gnt0, m_en} !== 3'b011) begin
            errs++; $display("FAIL rm_regrant: got gnt=%b%b m_en=%b expected 01/1", gnt1, gnt0, m_en);
        end
        req0 = 1'b0; rr_m = 1;
        run_txn(2, 12, -1, 8'h3C, addr0, 1'b1, wdata0, TO + 5, 1'b0);
        rd_m[0] = 8'h3C;
        vec++;
        if (obs_done_k != EN_HOLD + 1 || {obs_done0, obs_err0} !== 2'b10 || obs_rdata0 !== rd_m[0]) begin
            errs++; $display("FAIL rm_complete: got edge=%0d done0=%b err0=%b rdata0=%h expected %0d/1/0/%h",
                             obs_done_k, obs_done0, obs_err0, obs_rdata0, EN_HOLD + 1, rd_m[0]);
        end
    endtask

    initial begin
        arst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; rw0 = 1'b0; rw1 = 1'b0;
        wdata0 = '0; wdata1 = '0; m_busy = 1'b0; m_data_out = '0; conflict = 1'b0;
        rr_m = 0; rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_req_drop();
        test_random();
        test_contention();
        test_conflict();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter EN_HOLD, default 250, number of clk cycles m_en is held high per transaction.
REQ-002 Parameter TIMEOUT_CYCLES, default 20000, number of clk cycles from grant before a transaction is aborted.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 arst  input  1  reset, synchronous and active-high.
REQ-005 req0 / req1  input  1 each  transaction request from requester 0 / 1.
REQ-006 addr0 / addr1  input  7 each  target slave address.
REQ-007 rw0 / rw1  input  1 each  direction: 1 = read, 0 = write.
REQ-008 wdata0 / wdata1  input  8 each  write data.
REQ-009 gnt0 / gnt1  output  1 each  one-cycle pulse when the request is accepted.
REQ-010 done0 / done1  output  1 each  one-cycle pulse when the transaction ends.
REQ-011 err0 / err1  output  1 each  valid with done; 1 = timeout or conflict.
REQ-012 rdata0 / rdata1  output  8 each  last read data for that requester.
REQ-013 m_en  output  1  enable to the I2C master.
REQ-014 m_addr  output  7  address to the I2C master.
REQ-015 m_rw  output  1  direction to the I2C master.
REQ-016 m_data_in  output  8  write data to the I2C master.
REQ-017 m_busy  input  1  master busy.
REQ-018 m_data_out  input  8  master read data.
REQ-019 conflict  input  1  bus address-conflict flag from the address translator.

Function
REQ-020 The block SHALL implement the states IDLE, ISSUE, WAIT_RISE, WAIT_FALL and DONE.
REQ-021 In IDLE, on an edge with m_busy=0 and at least one req high, the block SHALL grant, pulse gnt, latch addr/rw/wdata, enter ISSUE and set m_en=1, all on that same edge.
REQ-022 The block SHALL NOT grant while m_busy=1.
REQ-023 With both req high, the block SHALL grant the port selected by the round-robin pointer, and the pointer SHALL move to the other port after every grant.
REQ-024 With a single req high, the block SHALL grant that port; the pointer then moves to the other port.
REQ-025 m_addr, m_rw and m_data_in SHALL come from the latched registers and stay stable from grant until DONE exits.
REQ-026 ISSUE SHALL hold m_en=1 for exactly EN_HOLD cycles, then drive m_en=0.
REQ-027 Leaving ISSUE, the block SHALL enter WAIT_FALL if m_busy was seen high during ISSUE, otherwise WAIT_RISE.
REQ-028 WAIT_RISE SHALL go to WAIT_FALL on m_busy=1.
REQ-029 WAIT_FALL SHALL go to DONE on m_busy=0.
REQ-030 On entry to DONE, the block SHALL pulse done of the granted port for exactly 1 cycle.
REQ-031 On entry to DONE for a read (rw=1), the block SHALL capture m_data_out into that port's rdata; a write SHALL leave rdata unchanged.
REQ-032 DONE SHALL last 1 cycle and then return to IDLE, giving at least 1 cycle between transactions.
REQ-033 A 16-bit-minimum timeout counter SHALL clear at grant; if it reaches TIMEOUT_CYCLES in ISSUE, WAIT_RISE or WAIT_FALL, the block SHALL force m_en=0 and enter DONE with err=1, leaving rdata unchanged.
REQ-034 conflict=1 in any cycle from grant to DONE SHALL set a sticky flag, reported as err=1 with done; the flag SHALL clear in IDLE.
REQ-035 err SHALL be 0 whenever done is 0.
REQ-036 Outputs of the non-granted port SHALL stay 0, except rdata, which holds its value.
REQ-037 req dropped before grant SHALL cause no transaction.
REQ-038 req still high after done SHALL be treated as a new request, subject to REQ-023.
REQ-039 req changes after grant SHALL NOT affect the transaction in flight.

Reset
REQ-040 arst=1 SHALL, on the next edge, force state IDLE, round-robin pointer to port 0, timeout counter and sticky flag to 0, and every output including rdata0/rdata1 and m_* to 0.
REQ-041 An arst mid-transaction SHALL discard that transaction with no done pulse.

Verification
REQ-042 Write: req0, addr0=7'h48, rw0=0, wdata0=8'hB3 -> gnt0 on the grant edge; m_en high for 250 cycles with m_addr=7'h48 and m_data_in=8'hB3; done0=1, err0=0 on the edge after m_busy falls.
REQ-043 Read: req1, addr1=7'h4F, rw1=1, master returns 8'h75 -> rdata1=8'h75, done1=1, err1=0; rdata0 unchanged.
REQ-044 Contention: req0 and req1 rise on the same edge after reset -> port 0 served first, then port 1 with no grant until m_busy=0, then port 0 again.
REQ-045 Timeout: m_busy held 0 throughout -> done=1, err=1 exactly TIMEOUT_CYCLES cycles after grant, m_en=0, rdata unchanged.
REQ-046 Conflict: conflict pulsed for 1 cycle during WAIT_FALL of a read -> done=1, err=1 and rdata updated; the next clean transaction ends with err=0.
REQ-047 Reset mid-transaction: arst during WAIT_FALL -> next edge all outputs 0, no done pulse; a new req0 with m_busy=0 is granted.
